// File: rtl/rv32_ctrl_pkg.sv
// Shared decode/EX control types, ALU op codes and the FP issue FSM states.
package rv32_ctrl_pkg;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_src;
    logic       jump;
    logic [2:0] alu_op;
    logic       lui;
    logic       auipc;
    logic       jal;
    logic       r_type;
    logic       rdata1_int_FP_sel;
    logic       rdata2_int_FP_sel;
    logic       FP_reg_write;
  } id_ctrl_t;

  localparam logic [2:0] ALU_OP_R_FLOAT  = 3'b100;
  localparam logic [2:0] ALU_OP_R4_FLOAT = 3'b101;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFpBusy = 2'd1,
    StFpHold = 2'd2
  } fp_state_e;

endpackage

// File: rtl/fp_lat_counter.sv
// 4-bit latency down-counter: load, saturating decrement, zero flag.
module fp_lat_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt_q;

  // Load takes priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/id_ex_fp_issue.sv
// ID/EX pipeline register with multi-cycle FP occupancy, FPU start pulse and stall generation.
module id_ex_fp_issue
  import rv32_ctrl_pkg::*;
#(
  parameter int unsigned FP_LAT_R  = 3,
  parameter int unsigned FP_LAT_R4 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid_i,
  input  id_ctrl_t    id_ctrl_i,
  input  logic [31:0] id_pc_i,
  input  logic [4:0]  id_rd_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        ex_valid_o,
  output id_ctrl_t    ex_ctrl_o,
  output logic [31:0] ex_pc_o,
  output logic [4:0]  ex_rd_o,
  output logic        fpu_start_o,
  output logic        fp_result_valid_o,
  output logic        stall_o
);

  logic        ex_valid_q;
  id_ctrl_t    ex_ctrl_q;
  logic [31:0] ex_pc_q;
  logic [4:0]  ex_rd_q;

  fp_state_e   state_q, state_d;
  logic        cnt_load, cnt_dec, cnt_zero;
  logic        is_fp, lat_one, advance;
  logic [3:0]  lat;

  assign is_fp   = ex_valid_q &&
                   ((ex_ctrl_q.alu_op == ALU_OP_R_FLOAT) || (ex_ctrl_q.alu_op == ALU_OP_R4_FLOAT));
  assign lat     = (ex_ctrl_q.alu_op == ALU_OP_R4_FLOAT) ? 4'(FP_LAT_R4) : 4'(FP_LAT_R);
  assign lat_one = (lat == 4'd1);

  // The first cycle of a multi-cycle FP op (still in StIdle) must already stall, otherwise the
  // op would leave EX after one cycle; busy then covers the remaining lat-2 stalled cycles.
  assign stall_o = !reset && (stall_i ||
                              ((state_q == StFpBusy) && !cnt_zero) ||
                              ((state_q == StIdle) && is_fp && !lat_one));
  assign advance = !stall_o;

  assign fpu_start_o       = !reset && (state_q == StIdle) && is_fp;
  assign fp_result_valid_o = !reset && (((state_q == StFpBusy) && cnt_zero) ||
                                        (state_q == StFpHold) ||
                                        ((state_q == StIdle) && is_fp && lat_one));

  // EX register: bubble on flush or empty ID, load ID when advancing, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_pc_q    <= 32'd0;
      ex_rd_q    <= 5'd0;
    end else if (advance) begin
      if (flush_i || !id_valid_i) begin
        ex_valid_q <= 1'b0;
        ex_ctrl_q  <= '0;
        ex_pc_q    <= 32'd0;
        ex_rd_q    <= 5'd0;
      end else begin
        ex_valid_q <= 1'b1;
        ex_ctrl_q  <= id_ctrl_i;
        ex_pc_q    <= id_pc_i;
        ex_rd_q    <= id_rd_i;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and counter control.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_fp) begin
          if (lat_one) begin
            if (stall_i) state_d = StFpHold;
          end else begin
            state_d  = StFpBusy;
            cnt_load = 1'b1;
          end
        end
      end
      StFpBusy: begin
        // Counts down even under external stall so latency is fixed.
        cnt_dec = !cnt_zero;
        if (cnt_zero) state_d = stall_i ? StFpHold : StIdle;
      end
      StFpHold: begin
        if (!stall_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  fp_lat_counter u_fp_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (lat - 4'd2),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign ex_valid_o = ex_valid_q;
  assign ex_ctrl_o  = ex_ctrl_q;
  assign ex_pc_o    = ex_pc_q;
  assign ex_rd_o    = ex_rd_q;

endmodule

// File: tb/tb_id_ex_fp_issue.sv
// Self-checking bench for id_ex_fp_issue: occupancy-age model plus directed literal checks.
module tb_id_ex_fp_issue;
  import rv32_ctrl_pkg::*;

  localparam int LAT_R  = 3;
  localparam int LAT_R4 = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid_i;
  id_ctrl_t    id_ctrl_i;
  logic [31:0] id_pc_i;
  logic [4:0]  id_rd_i;
  logic        stall_i;
  logic        flush_i;
  logic        ex_valid_o;
  id_ctrl_t    ex_ctrl_o;
  logic [31:0] ex_pc_o;
  logic [4:0]  ex_rd_o;
  logic        fpu_start_o;
  logic        fp_result_valid_o;
  logic        stall_o;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  id_ex_fp_issue #(.FP_LAT_R(LAT_R), .FP_LAT_R4(LAT_R4)) dut (
    .clk               (clk),
    .reset             (reset),
    .id_valid_i        (id_valid_i),
    .id_ctrl_i         (id_ctrl_i),
    .id_pc_i           (id_pc_i),
    .id_rd_i           (id_rd_i),
    .stall_i           (stall_i),
    .flush_i           (flush_i),
    .ex_valid_o        (ex_valid_o),
    .ex_ctrl_o         (ex_ctrl_o),
    .ex_pc_o           (ex_pc_o),
    .ex_rd_o           (ex_rd_o),
    .fpu_start_o       (fpu_start_o),
    .fp_result_valid_o (fp_result_valid_o),
    .stall_o           (stall_o)
  );

  always #5 clk = ~clk;

  // Model: what sits in EX and how many cycles it has been there.
  logic        m_valid = 1'b0;
  id_ctrl_t    m_ctrl  = '0;
  logic [31:0] m_pc    = 32'd0;
  logic [4:0]  m_rd    = 5'd0;
  int          m_age   = 0;

  function automatic bit m_fp();
    return m_valid && (m_ctrl.alu_op == 3'b100 || m_ctrl.alu_op == 3'b101);
  endfunction

  function automatic int m_lat();
    return (m_ctrl.alu_op == 3'b101) ? LAT_R4 : LAT_R;
  endfunction

  // An FP op must stay for lat cycles; stall until its last cycle.
  function automatic bit m_stall();
    return !reset && (stall_i || (m_fp() && m_age < m_lat() - 1));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0; m_ctrl <= '0; m_pc <= 32'd0; m_rd <= 5'd0; m_age <= 0;
    end else if (!m_stall()) begin
      m_valid <= id_valid_i && !flush_i;
      m_ctrl  <= (id_valid_i && !flush_i) ? id_ctrl_i : '0;
      m_pc    <= (id_valid_i && !flush_i) ? id_pc_i : 32'd0;
      m_rd    <= (id_valid_i && !flush_i) ? id_rd_i : 5'd0;
      m_age   <= 0;
    end else if (m_age < 100) begin
      m_age   <= m_age + 1;
    end
  end

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      cmp("mon_ex_valid", 32'(ex_valid_o), 32'(m_valid));
      cmp("mon_ex_ctrl", 32'(ex_ctrl_o), 32'(m_ctrl));
      cmp("mon_ex_pc", ex_pc_o, m_pc);
      cmp("mon_ex_rd", 32'(ex_rd_o), 32'(m_rd));
      cmp("mon_fpu_start", 32'(fpu_start_o), 32'(!reset && m_fp() && m_age == 0));
      cmp("mon_fp_result_valid", 32'(fp_result_valid_o),
          32'(!reset && m_fp() && m_age >= m_lat() - 1));
      cmp("mon_stall", 32'(stall_o), 32'(m_stall()));
    end
  end

  function automatic id_ctrl_t mk(input logic [2:0] op, input bit fp, input bit st, input bit jl);
    id_ctrl_t c;
    c = '0;
    c.alu_op = op;
    if (fp) begin
      c.FP_reg_write = 1'b1; c.rdata1_int_FP_sel = 1'b1; c.rdata2_int_FP_sel = 1'b1;
    end else if (st) begin
      c.mem_write = 1'b1; c.alu_src = 1'b1;
    end else if (jl) begin
      c.jal = 1'b1; c.jump = 1'b1; c.reg_write = 1'b1;
    end else begin
      c.reg_write = 1'b1; c.r_type = 1'b1;
    end
    return c;
  endfunction

  task automatic drive(input logic v, input id_ctrl_t c, input logic [31:0] pc,
                       input logic [4:0] rd, input logic st, input logic fl);
    id_valid_i = v; id_ctrl_i = c; id_pc_i = pc; id_rd_i = rd; stall_i = st; flush_i = fl;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  id_ctrl_t c_add, c_sw, c_fadd, c_fmadd, c_jal;

  initial begin
    c_add   = mk(3'b011, 0, 0, 0);
    c_sw    = mk(3'b000, 0, 1, 0);
    c_fadd  = mk(3'b100, 1, 0, 0);
    c_fmadd = mk(3'b101, 1, 0, 0);
    c_jal   = mk(3'b000, 0, 0, 1);

    // Reset with every input active.
    reset = 1'b1;
    drive(1, c_fadd, 32'h50, 5'd7, 1, 1);
    next();
    mon_en = 1'b1;
    next();
    #1;
    cmp("rst_ex_valid", 32'(ex_valid_o), 32'd0);
    cmp("rst_stall", 32'(stall_o), 32'd0);
    cmp("rst_ex_pc", ex_pc_o, 32'd0);
    reset = 1'b0;
    drive(0, '0, 32'd0, 5'd0, 0, 0);
    next();
    cmp("post_rst_outputs", {ex_valid_o, fpu_start_o, fp_result_valid_o, stall_o}, 32'd0);

    // Integer ADD then SW, one cycle each.
    drive(1, c_add, 32'h100, 5'd1, 0, 0);
    next();
    drive(1, c_sw, 32'h104, 5'd2, 0, 0);
    #1;
    cmp("add_pc", ex_pc_o, 32'h100);
    cmp("add_stall", 32'(stall_o), 32'd0);
    next();
    drive(0, '0, 32'd0, 5'd0, 0, 0);
    #1;
    cmp("sw_pc", ex_pc_o, 32'h104);
    next();

    // FADD, latency 3: start at c0, stall c0-c1, result c2, next op in EX at c3.
    drive(1, c_fadd, 32'h200, 5'd3, 0, 0);
    next();
    drive(1, c_add, 32'h204, 5'd4, 0, 0);
    #1;
    cmp("fadd_c0", {fpu_start_o, stall_o, fp_result_valid_o}, 32'b110);
    next(); #1;
    cmp("fadd_c1", {fpu_start_o, stall_o, fp_result_valid_o}, 32'b010);
    next(); #1;
    cmp("fadd_c2", {fpu_start_o, stall_o, fp_result_valid_o}, 32'b001);
    next();
    drive(0, '0, 32'd0, 5'd0, 0, 0);
    #1;
    cmp("fadd_c3_pc", ex_pc_o, 32'h204);
    next();

    // FMADD, latency 4, stall_i on c2-c5: result from c3 on, single start, leaves after c6.
    drive(1, c_fmadd, 32'h300, 5'd5, 0, 0);
    next();
    drive(1, c_add, 32'h304, 5'd6, 0, 0);
    next();
    next();
    stall_i = 1'b1;
    next(); #1;
    cmp("fmadd_c3", {fpu_start_o, stall_o, fp_result_valid_o}, 32'b011);
    next();
    next(); #1;
    cmp("fmadd_c5_pc", ex_pc_o, 32'h300);
    next();
    stall_i = 1'b0;
    #1;
    cmp("fmadd_c6_stall", 32'(stall_o), 32'd0);
    next();
    drive(0, '0, 32'd0, 5'd0, 0, 0);
    #1;
    cmp("fmadd_c7_pc", ex_pc_o, 32'h304);
    next();

    // Flush of a JAL with no stall gives a bubble.
    drive(1, c_jal, 32'h400, 5'd1, 0, 1);
    next();
    drive(0, '0, 32'd0, 5'd0, 0, 0);
    #1;
    cmp("flush_bubble", {ex_valid_o, 16'(ex_ctrl_o)}, 32'd0);
    next();

    // Flush while an FP op stalls: EX holds until the op completes, then a bubble.
    drive(1, c_fadd, 32'h500, 5'd9, 0, 0);
    next();
    drive(1, c_jal, 32'h504, 5'd1, 0, 1);
    next(); #1;
    cmp("flush_fp_hold_pc", ex_pc_o, 32'h500);
    next();
    next();
    drive(0, '0, 32'd0, 5'd0, 0, 0);
    #1;
    cmp("flush_fp_after", 32'(ex_valid_o), 32'd0);
    next();

    // Reset during cycle 1 of an FMADD.
    drive(1, c_fmadd, 32'h600, 5'd2, 0, 0);
    next();
    drive(1, c_add, 32'h604, 5'd3, 0, 0);
    next();
    reset = 1'b1;
    #1;
    cmp("rst_mid_rv", 32'(fp_result_valid_o), 32'd0);
    next();
    reset = 1'b0;
    drive(0, '0, 32'd0, 5'd0, 0, 0);
    #1;
    cmp("rst_mid_after", {ex_valid_o, stall_o, fp_result_valid_o, fpu_start_o}, 32'd0);
    next(); next(); next();

    // Back-to-back FP ops with stall during the first, then mixed traffic.
    drive(1, c_fmadd, 32'h700, 5'd1, 0, 0);
    next();
    drive(1, c_fadd, 32'h704, 5'd2, 0, 0);
    next();
    stall_i = 1'b1;
    next();
    stall_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      next();
      drive(1, (i % 3 == 0) ? c_fadd : ((i % 3 == 1) ? c_sw : c_fmadd),
            32'h800 + 32'(4 * i), 5'(i), (i == 5), (i == 8));
    end
    next();
    drive(0, '0, 32'd0, 5'd0, 0, 0);
    for (int i = 0; i < 8; i++) next();

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
